// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for a MIPS-subset datapath (lw, sw, R-type, beq).
// One state per cycle, shared memory port with ready handshake, timeout and illegal flags.
module mc_ctrl_fsm #(
    parameter logic [5:0]  OP_LW       = 6'h23,
    parameter logic [5:0]  OP_SW       = 6'h2B,
    parameter logic [5:0]  OP_RTYPE    = 6'h00,
    parameter logic [5:0]  OP_BEQ      = 6'h04,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic [15:0] instr_count,
    output logic        illegal,
    output logic        timeout
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    localparam logic [3:0] StFetch   = 4'd0;
    localparam logic [3:0] StDecode  = 4'd1;
    localparam logic [3:0] StMemAddr = 4'd2;
    localparam logic [3:0] StMemRd   = 4'd3;
    localparam logic [3:0] StMemWb   = 4'd4;
    localparam logic [3:0] StMemWr   = 4'd5;
    localparam logic [3:0] StExec    = 4'd6;
    localparam logic [3:0] StRWb     = 4'd7;
    localparam logic [3:0] StBranch  = 4'd8;
    localparam logic [3:0] StHalt    = 4'd9;

    logic [3:0]       state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [15:0]      count_q, count_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             mem_wait;

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        mem_wait   = 1'b0;
        state_d    = state_q;
        wait_d     = '0;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;

        // In reset every strobe/select stays at its zero default.
        if (rst) begin
            case (state_q)
                StFetch: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = StDecode;
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                StDecode: begin
                    alu_src_b = 2'b11;
                    if (opcode == OP_LW || opcode == OP_SW) begin
                        state_d = StMemAddr;
                    end else if (opcode == OP_RTYPE) begin
                        state_d = StExec;
                    end else if (opcode == OP_BEQ) begin
                        state_d = StBranch;
                    end else begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                end
                StMemAddr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_LW) ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_d = StMemWb;
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
                StMemWr: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                StExec: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = StRWb;
                end
                StRWb: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
                StBranch: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b01;
                    pc_src     = 1'b1;
                    pc_write   = alu_zero;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StHalt;
                end
            endcase

            // A ready on the limit cycle takes the normal path above instead.
            if (mem_wait) begin
                if (wait_q == WaitLast) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
        end

        count_d = count_q + {15'd0, instr_done};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            count_q   <= 16'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;

endmodule
